// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, FSM states, flag layout and immediate sign-extension for cpu_param
package cpu_pkg;
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3,
    OP_SUB  = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
    OP_ADDI = 4'h8, OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB,
    OP_CMP  = 4'hC, OP_SHL = 4'hD, OP_SHR = 4'hE, OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_e;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;

  // Sign-extends the low w bits of v to 64 bits; callers size-cast to their width.
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] m;
    logic s;
    m = {64{1'b1}} << w;
    s = |(v & (64'd1 << (w - 1)));
    return s ? (v | m) : (v & ~m);
  endfunction
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU producing result plus carry/borrow and zero for cpu_param
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  opcode_e           op_i,
  output logic [DATA_W-1:0] res_o,
  output logic              c_o,
  output logic              z_o
);
  logic [DATA_W:0] sum, dif;

  assign sum = {1'b0, a_i} + {1'b0, b_i};
  assign dif = {1'b0, a_i} - {1'b0, b_i};
  assign z_o = res_o == '0;

  // Operation select; the top bit of the widened difference is the unsigned borrow.
  always_comb begin
    res_o = b_i;
    c_o = 1'b0;
    case (op_i)
      OP_ADD, OP_ADDI: {c_o, res_o} = sum;
      OP_SUB, OP_CMP:  {c_o, res_o} = dif;
      OP_AND:          res_o = a_i & b_i;
      OP_OR:           res_o = a_i | b_i;
      OP_XOR:          res_o = a_i ^ b_i;
      OP_SHL:          {c_o, res_o} = {a_i, 1'b0};
      OP_SHR:          {res_o, c_o} = {1'b0, a_i};
      default:         res_o = b_i;
    endcase
  end
endmodule

// File: rtl/cpu_param.sv
// cpu_param: parametrised multicycle CPU with handshaked fetch; CPU_DBG_EN adds a register/flag debug port
module cpu_param
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG = 4,
  parameter int IMM_W = 8,
  parameter int ADDR_W = 16,
  localparam int RSEL_W = $clog2(NREG),
  localparam int INS_W = 4 + 2 * RSEL_W + IMM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic              en_ram_out,
  input  logic [INS_W-1:0]  ins,
`ifdef CPU_DBG_EN
  input  logic [RSEL_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [1:0]        dbg_flags,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              en_ram_in,
  output logic              halted,
  output logic              retire
);
  logic [DATA_W-1:0] regs_q [NREG];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INS_W-1:0]  ir_q, ir_d;
  flags_t            flags_q, flags_d;
  opcode_e           op;
  logic [RSEL_W-1:0] rd, rs;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] sx_d, a, b, alu_res;
  logic [ADDR_W-1:0] sx_a;
  logic              alu_c, alu_z, wr, fl, taken;

  assign op    = opcode_e'(ir_q[INS_W-1 -: 4]);
  assign rd    = ir_q[INS_W-5 -: RSEL_W];
  assign rs    = ir_q[INS_W-5-RSEL_W -: RSEL_W];
  assign imm   = ir_q[IMM_W-1:0];
  assign sx_d  = DATA_W'(sext(64'(imm), IMM_W));
  assign sx_a  = ADDR_W'(sext(64'(imm), IMM_W));
  assign a     = regs_q[rd];
  assign b     = (op == OP_LDI || op == OP_ADDI) ? sx_d : regs_q[rs];
  assign wr    = op inside {OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_SHL, OP_SHR};
  assign fl    = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_CMP, OP_SHL, OP_SHR};
  assign taken = op == OP_JMP || (op == OP_JZ && flags_q.z) || (op == OP_JC && flags_q.c);

  assign addr      = pc_q;
  assign en_ram_in = state_q == S_FETCH;
  assign halted    = state_q == S_HALT;
  assign retire    = state_q == S_EXEC;

`ifdef CPU_DBG_EN
  assign dbg_data  = regs_q[dbg_sel];
  assign dbg_flags = {flags_q.c, flags_q.z};
`endif

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i(a), .b_i(b), .op_i(op), .res_o(alu_res), .c_o(alu_c), .z_o(alu_z)
  );

  // Sequencing: fetch handshake, single-edge execute, pause to IDLE and sticky HALT.
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    flags_d = flags_q;
    case (state_q)
      S_IDLE:  state_d = en_in ? S_FETCH : S_IDLE;
      S_FETCH: begin
        ir_d = en_ram_out ? ins : ir_q;
        state_d = en_ram_out ? S_EXEC : en_in ? S_FETCH : S_IDLE;
      end
      S_EXEC:  begin
        pc_d = pc_q + ADDR_W'(1) + (taken ? sx_a : '0);
        flags_d = fl ? flags_t'({alu_c, alu_z}) : flags_q;
        state_d = op == OP_HALT ? S_HALT : en_in ? S_FETCH : S_IDLE;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Control state, PC, IR and flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      ir_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Register file; writeback happens only on the EXEC edge of a writing opcode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (state_q == S_EXEC && wr) begin
      regs_q[rd] <= alu_res;
    end
  end
endmodule

// File: tb/tb_cpu_param.sv
// tb_cpu_param: directed vector and sequence bench for cpu_param (default build, plus an ADDR_W=4 instance for PC wrap)
module tb_cpu_param;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0, en_in = 1'b0, en_ram_out = 1'b0;
  logic [15:0] ins, addr;
  logic        en_ram_in, halted, retire;
  logic [15:0] mem [256];

  logic        rst2 = 1'b0, en_in2 = 1'b0, en_ram_out2 = 1'b1;
  logic [11:0] ins2;
  logic [3:0]  addr2;
  logic        en_ram_in2, halted2, retire2;
  logic [11:0] mem2 [16];

  int ncmp = 0, nfail = 0;

  always #5 clk = ~clk;

  assign ins  = (addr < 16'd256) ? mem[addr[7:0]] : 16'h0;
  assign ins2 = mem2[addr2];

  cpu_param dut (
    .clk(clk), .rst(rst), .en_in(en_in), .en_ram_out(en_ram_out), .ins(ins),
    .addr(addr), .en_ram_in(en_ram_in), .halted(halted), .retire(retire)
  );

  cpu_param #(.ADDR_W(4), .IMM_W(4)) dut2 (
    .clk(clk), .rst(rst2), .en_in(en_in2), .en_ram_out(en_ram_out2), .ins(ins2),
    .addr(addr2), .en_ram_in(en_ram_in2), .halted(halted2), .retire(retire2)
  );

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r0;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [15:0] enc(logic [3:0] op, logic [1:0] rd, logic [1:0] rs, logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    en_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_to_halt(output int nret);
    nret = 0;
    en_ram_out = 1'b1;
    en_in = 1'b1;
    for (int i = 0; i < 200 && !halted; i++) begin
      @(negedge clk);
      if (retire) nret++;
    end
    if (!halted) chk("halt_timeout", halted, 1);
  endtask

  task automatic t_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_req", en_ram_in, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retire", retire, 0);
    chk("rst_r0", dut.regs_q[0], 0);
    chk("rst_flags", {dut.flags_q.c, dut.flags_q.z}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_req", en_ram_in, 0);
  endtask

  task automatic t_vectors();
    int nret;
    for (int i = 0; i < 14; i++) begin
      clr_mem();
      mem[0] = enc(OP_LDI, 0, 0, vecs[i].a);
      mem[1] = enc(OP_LDI, 1, 0, vecs[i].b);
      mem[2] = enc(vecs[i].op, 0, 1, vecs[i].b);
      mem[3] = enc(OP_HALT, 0, 0, 0);
      reset_dut();
      run_to_halt(nret);
      chk($sformatf("vec%0d_r0", i), dut.regs_q[0], vecs[i].r0);
      chk($sformatf("vec%0d_z", i), dut.flags_q.z, vecs[i].z);
      chk($sformatf("vec%0d_c", i), dut.flags_q.c, vecs[i].c);
      chk($sformatf("vec%0d_retires", i), nret, 4);
    end
  endtask

  task automatic t_timing();
    int rq[$];
    bit hold_ok = 1'b1;
    clr_mem();
    mem[0] = enc(OP_LDI, 0, 0, 8'd5);
    mem[1] = enc(OP_LDI, 1, 0, 8'd3);
    mem[2] = enc(OP_ADD, 0, 1, 8'd0);
    mem[3] = enc(OP_HALT, 0, 0, 0);
    reset_dut();
    en_ram_out = 1'b1;
    en_in = 1'b1;
    for (int cnt = 1; cnt <= 14; cnt++) begin
      @(negedge clk);
      if (retire) rq.push_back(cnt);
      if (cnt >= 9 && (!halted || en_ram_in)) hold_ok = 1'b0;
    end
    chk("tim_retire_count", rq.size(), 4);
    for (int k = 0; k < 4; k++) chk("tim_retire_cycle", k < rq.size() ? rq[k] : -1, 2 * (k + 1));
    chk("tim_halt_hold", hold_ok, 1);
    chk("tim_r0", dut.regs_q[0], 16'd8);
    chk("tim_flags", {dut.flags_q.c, dut.flags_q.z}, 0);
  endtask

  task automatic t_jz();
    int aq[$];
    int exp_a[4] = '{0, 1, 2, 5};
    clr_mem();
    mem[0] = enc(OP_LDI, 0, 0, 8'hFF);
    mem[1] = enc(OP_ADDI, 0, 0, 8'h01);
    mem[2] = enc(OP_JZ, 0, 0, 8'h02);
    mem[3] = enc(OP_LDI, 2, 0, 8'h55);
    mem[4] = enc(OP_LDI, 2, 0, 8'h55);
    mem[5] = enc(OP_HALT, 0, 0, 0);
    reset_dut();
    en_ram_out = 1'b1;
    en_in = 1'b1;
    for (int i = 0; i < 40 && !halted; i++) begin
      @(negedge clk);
      if (en_ram_in) aq.push_back(int'(addr));
    end
    chk("jz_fetch_count", aq.size(), 4);
    for (int k = 0; k < 4; k++) chk("jz_fetch_addr", k < aq.size() ? aq[k] : -1, exp_a[k]);
    chk("jz_r0", dut.regs_q[0], 0);
    chk("jz_z", dut.flags_q.z, 1);
    chk("jz_c", dut.flags_q.c, 1);
    chk("jz_r2_skipped", dut.regs_q[2], 0);
  endtask

  task automatic t_stall();
    int nret;
    clr_mem();
    mem[0] = enc(OP_LDI, 1, 0, 8'h12);
    mem[1] = enc(OP_HALT, 0, 0, 0);
    reset_dut();
    en_ram_out = 1'b0;
    en_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_req_noret", {en_ram_in, retire}, 2'b10);
      chk("stall_addr", addr, 0);
      chk("stall_ir", dut.ir_q, 0);
      if (k == 3) en_ram_out = 1'b1;
    end
    @(negedge clk);
    chk("stall_exec", {en_ram_in, retire}, 2'b01);
    chk("stall_ir_load", dut.ir_q, enc(OP_LDI, 1, 0, 8'h12));
    run_to_halt(nret);
    chk("stall_r1", dut.regs_q[1], 16'h12);
  endtask

  task automatic t_pause();
    int nret;
    bit found = 1'b0;
    clr_mem();
    mem[0] = enc(OP_LDI, 1, 0, 8'h44);
    mem[6] = enc(OP_LDI, 3, 0, 8'h21);
    mem[7] = enc(OP_LDI, 2, 0, 8'h33);
    mem[8] = enc(OP_HALT, 0, 0, 0);
    reset_dut();
    en_ram_out = 1'b1;
    en_in = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (retire && addr == 16'd6) begin
        en_in = 1'b0;
        found = 1'b1;
      end
    end
    chk("pause_found", found, 1);
    repeat (3) @(negedge clk);
    chk("pause_idle", {en_ram_in, retire, halted}, 0);
    chk("pause_addr", addr, 16'd7);
    chk("pause_r3", dut.regs_q[3], 16'h21);
    chk("pause_r1", dut.regs_q[1], 16'h44);
    chk("pause_r2", dut.regs_q[2], 0);
    en_in = 1'b1;
    @(negedge clk);
    chk("resume_req", en_ram_in, 1);
    chk("resume_addr", addr, 16'd7);
    run_to_halt(nret);
    chk("resume_r2", dut.regs_q[2], 16'h33);
    chk("resume_r1", dut.regs_q[1], 16'h44);
  endtask

  task automatic t_reset_mid();
    clr_mem();
    mem[0] = enc(OP_LDI, 0, 0, 8'h09);
    reset_dut();
    en_ram_out = 1'b0;
    en_in = 1'b1;
    @(negedge clk);
    chk("rmid_fetching", en_ram_in, 1);
    rst = 1'b0;
    en_ram_out = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    en_in = 1'b0;
    chk("rmid_outs", {en_ram_in, retire, halted}, 0);
    chk("rmid_addr", addr, 0);
    chk("rmid_ir", dut.ir_q, 0);
    chk("rmid_state", dut.state_q, S_IDLE);
    @(negedge clk);
    chk("rmid_r0", dut.regs_q[0], 0);
    chk("rmid_still_idle", {en_ram_in, retire}, 0);
  endtask

  task automatic t_wrap();
    int nret = 0;
    int aq[$];
    bit at15 = 1'b0;
    for (int i = 0; i < 16; i++) mem2[i] = 12'h0;
    @(negedge clk);
    rst2 = 1'b0;
    en_in2 = 1'b0;
    repeat (2) @(negedge clk);
    rst2 = 1'b1;
    en_in2 = 1'b1;
    for (int i = 0; i < 200 && !at15; i++) begin
      @(negedge clk);
      if (retire2) nret++;
      if (en_ram_in2 && addr2 == 4'd15) at15 = 1'b1;
    end
    chk("wrap_reach15", at15, 1);
    chk("wrap_retires", nret, 15);
    mem2[0] = {4'h9, 2'b00, 2'b00, 4'hF};
    for (int i = 0; i < 20 && aq.size() < 3; i++) begin
      @(negedge clk);
      if (en_ram_in2) aq.push_back(int'(addr2));
    end
    chk("wrap_fetch_count", aq.size(), 3);
    for (int k = 0; k < 3; k++) chk("wrap_fetch_addr", k < aq.size() ? aq[k] : -1, 0);
    chk("wrap_not_halted", halted2, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{OP_ADD,  8'd5,   8'd3,   16'h0008, 1'b0, 1'b0};
    vecs[1]  = '{OP_ADD,  8'hFF,  8'd1,   16'h0000, 1'b1, 1'b1};
    vecs[2]  = '{OP_SUB,  8'd3,   8'd5,   16'hFFFE, 1'b0, 1'b1};
    vecs[3]  = '{OP_SUB,  8'd5,   8'd5,   16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{OP_AND,  8'h0C,  8'h0A,  16'h0008, 1'b0, 1'b0};
    vecs[5]  = '{OP_OR,   8'h0C,  8'h0A,  16'h000E, 1'b0, 1'b0};
    vecs[6]  = '{OP_XOR,  8'h0C,  8'h0C,  16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{OP_ADDI, 8'hFF,  8'h01,  16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{OP_CMP,  8'd3,   8'd5,   16'h0003, 1'b0, 1'b1};
    vecs[9]  = '{OP_SHL,  8'h80,  8'd0,   16'hFF00, 1'b0, 1'b1};
    vecs[10] = '{OP_SHR,  8'd1,   8'd0,   16'h0000, 1'b1, 1'b1};
    vecs[11] = '{OP_MOV,  8'd7,   8'hFE,  16'hFFFE, 1'b0, 1'b0};
    vecs[12] = '{OP_NOP,  8'd7,   8'd9,   16'h0007, 1'b0, 1'b0};
    vecs[13] = '{OP_LDI,  8'd7,   8'h80,  16'hFF80, 1'b0, 1'b0};
    t_reset();
    t_vectors();
    t_timing();
    t_jz();
    t_stall();
    t_pause();
    t_reset_mid();
    t_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
